// File: rtl/cci_mpf_svc_vtp_pt_miss_arb.sv
`default_nettype none
// ============================================================================
// Module   : cci_mpf_svc_vtp_pt_miss_arb
// Purpose  : Round-robin arbiter for TLB-miss requests ahead of the VTP
//            page-table walker. Misses to a 4KB page that already has a walk
//            in flight are merged, so each unique page is walked once. Every
//            walk response is broadcast to all clients that asked for it.
// Revision : 1.0  initial release
// ============================================================================
module cci_mpf_svc_vtp_pt_miss_arb #(
    parameter int N_CLIENTS   = 2,
    parameter int N_TRACK     = 4,
    parameter int VA_IDX_BITS = 36,
    parameter int PA_IDX_BITS = 40
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [N_CLIENTS-1:0]             miss_valid,
    output logic [N_CLIENTS-1:0]             miss_rdy,
    input  logic [N_CLIENTS*VA_IDX_BITS-1:0] miss_va,
    output logic                             walk_req_en,
    input  logic                             walk_req_rdy,
    output logic [VA_IDX_BITS-1:0]           walk_req_va,
    output logic [$clog2(N_TRACK)-1:0]       walk_req_tag,
    input  logic                             walk_rsp_en,
    input  logic [$clog2(N_TRACK)-1:0]       walk_rsp_tag,
    input  logic [PA_IDX_BITS-1:0]           walk_rsp_pa,
    input  logic                             walk_rsp_is_big_page,
    input  logic                             walk_rsp_not_present,
    output logic                             cli_rsp_valid,
    output logic [N_CLIENTS-1:0]             cli_rsp_mask,
    output logic [VA_IDX_BITS-1:0]           cli_rsp_va,
    output logic [PA_IDX_BITS-1:0]           cli_rsp_pa,
    output logic                             cli_rsp_is_big_page,
    output logic                             cli_rsp_not_present,
    output logic                             busy,
    output logic [15:0]                      stat_merge_cnt,
    output logic                             err_bad_tag
);

    localparam int c_tag_w = $clog2(N_TRACK);
    localparam int c_cli_w = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

    // Tracker entries: a set valid bit means the walk is PENDING.
    logic [N_TRACK-1:0]     r_valid;
    logic [VA_IDX_BITS-1:0] r_va   [N_TRACK];
    logic [N_CLIENTS-1:0]   r_mask [N_TRACK];
    logic [c_cli_w-1:0]     r_rr;

    logic                   r_walk_req_en;
    logic [VA_IDX_BITS-1:0] r_walk_req_va;
    logic [c_tag_w-1:0]     r_walk_req_tag;

    logic                   r_cli_rsp_valid;
    logic [N_CLIENTS-1:0]   r_cli_rsp_mask;
    logic [VA_IDX_BITS-1:0] r_cli_rsp_va;
    logic [PA_IDX_BITS-1:0] r_cli_rsp_pa;
    logic                   r_cli_rsp_is_big_page;
    logic                   r_cli_rsp_not_present;
    logic                   r_busy;
    logic [15:0]            r_merge_cnt;
    logic                   r_err_bad_tag;

    logic                   w_win_found;
    logic [c_cli_w-1:0]     w_win_idx;
    logic [N_CLIENTS-1:0]   w_win_onehot;
    logic [VA_IDX_BITS-1:0] w_win_va;
    logic                   w_rsp_free;
    logic                   w_hit;
    logic [c_tag_w-1:0]     w_hit_idx;
    logic                   w_free_found;
    logic [c_tag_w-1:0]     w_free_idx;
    logic                   w_merge;
    logic                   w_alloc;
    logic [c_cli_w-1:0]     w_rr_nxt;
    logic [N_TRACK-1:0]     w_valid_nxt;

    // Pick the winner, look it up in the tracker and decide merge/allocate/stall.
    always_comb begin
        int w_cand;
        w_win_found  = 1'b0;
        w_win_idx    = '0;
        w_hit        = 1'b0;
        w_hit_idx    = '0;
        w_free_found = 1'b0;
        w_free_idx   = '0;
        w_cand       = 0;

        for (int k = 0; k < N_CLIENTS; k++) begin
            w_cand = (int'(r_rr) + k) % N_CLIENTS;
            if (!w_win_found && miss_valid[w_cand]) begin
                w_win_found = 1'b1;
                w_win_idx   = c_cli_w'(w_cand);
            end
        end

        w_win_va     = miss_va[int'(w_win_idx)*VA_IDX_BITS +: VA_IDX_BITS];
        w_win_onehot = {{(N_CLIENTS-1){1'b0}}, 1'b1} << w_win_idx;

        // An entry being retired this cycle has already had its mask
        // captured for the broadcast, so it must not absorb a merge.
        w_rsp_free = walk_rsp_en & r_valid[walk_rsp_tag];

        for (int t = 0; t < N_TRACK; t++) begin
            if (!w_hit && r_valid[t] && r_va[t] == w_win_va &&
                !(w_rsp_free && walk_rsp_tag == c_tag_w'(t))) begin
                w_hit     = 1'b1;
                w_hit_idx = c_tag_w'(t);
            end
            // Free as of cycle start: the slot retired this cycle is not reused yet.
            if (!w_free_found && !r_valid[t]) begin
                w_free_found = 1'b1;
                w_free_idx   = c_tag_w'(t);
            end
        end

        w_merge  = w_win_found & w_hit;
        w_alloc  = w_win_found & ~w_hit & w_free_found & walk_req_rdy;
        miss_rdy = (w_merge | w_alloc) ? w_win_onehot : '0;
        w_rr_nxt = (w_win_idx == c_cli_w'(N_CLIENTS-1)) ? '0 : w_win_idx + c_cli_w'(1);

        w_valid_nxt = r_valid;
        if (w_rsp_free) w_valid_nxt[walk_rsp_tag] = 1'b0;
        if (w_alloc)    w_valid_nxt[w_free_idx]   = 1'b1;
    end

    // Tracker contents and round-robin pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
            r_rr    <= '0;
            for (int t = 0; t < N_TRACK; t++) begin
                r_va[t]   <= '0;
                r_mask[t] <= '0;
            end
        end else begin
            r_valid <= w_valid_nxt;
            if (w_alloc) begin
                r_va[w_free_idx]   <= w_win_va;
                r_mask[w_free_idx] <= w_win_onehot;
            end
            if (w_merge) r_mask[w_hit_idx] <= r_mask[w_hit_idx] | w_win_onehot;
            if (w_merge | w_alloc) r_rr <= w_rr_nxt;
        end
    end

    // Issue one walk request per newly allocated entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_walk_req_en  <= 1'b0;
            r_walk_req_va  <= '0;
            r_walk_req_tag <= '0;
        end else begin
            r_walk_req_en <= w_alloc;
            if (w_alloc) begin
                r_walk_req_va  <= w_win_va;
                r_walk_req_tag <= w_free_idx;
            end
        end
    end

    // Broadcast walk responses one cycle later; flag responses to idle tags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cli_rsp_valid       <= 1'b0;
            r_cli_rsp_mask        <= '0;
            r_cli_rsp_va          <= '0;
            r_cli_rsp_pa          <= '0;
            r_cli_rsp_is_big_page <= 1'b0;
            r_cli_rsp_not_present <= 1'b0;
            r_err_bad_tag         <= 1'b0;
        end else begin
            r_cli_rsp_valid <= w_rsp_free;
            r_err_bad_tag   <= walk_rsp_en & ~r_valid[walk_rsp_tag];
            if (w_rsp_free) begin
                r_cli_rsp_mask        <= r_mask[walk_rsp_tag];
                r_cli_rsp_va          <= r_va[walk_rsp_tag];
                r_cli_rsp_pa          <= walk_rsp_pa;
                r_cli_rsp_is_big_page <= walk_rsp_is_big_page;
                r_cli_rsp_not_present <= walk_rsp_not_present;
            end else begin
                r_cli_rsp_mask <= '0;
            end
        end
    end

    // Occupancy flag and saturating merge statistic.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy      <= 1'b0;
            r_merge_cnt <= '0;
        end else begin
            r_busy <= |w_valid_nxt;
            if (w_merge && r_merge_cnt != 16'hFFFF) r_merge_cnt <= r_merge_cnt + 16'd1;
        end
    end

    assign walk_req_en         = r_walk_req_en;
    assign walk_req_va         = r_walk_req_va;
    assign walk_req_tag        = r_walk_req_tag;
    assign cli_rsp_valid       = r_cli_rsp_valid;
    assign cli_rsp_mask        = r_cli_rsp_mask;
    assign cli_rsp_va          = r_cli_rsp_va;
    assign cli_rsp_pa          = r_cli_rsp_pa;
    assign cli_rsp_is_big_page = r_cli_rsp_is_big_page;
    assign cli_rsp_not_present = r_cli_rsp_not_present;
    assign busy                = r_busy;
    assign stat_merge_cnt      = r_merge_cnt;
    assign err_bad_tag         = r_err_bad_tag;

endmodule
`default_nettype wire

// File: tb/tb_cci_mpf_svc_vtp_pt_miss_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_cci_mpf_svc_vtp_pt_miss_arb
// Purpose  : Randomized, scoreboard-based bench for the page-walk miss arbiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_cci_mpf_svc_vtp_pt_miss_arb;

    localparam int NC = 2;
    localparam int NT = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [1:0]  miss_valid = '0;
    logic [1:0]  miss_rdy;
    logic [71:0] miss_va = '0;
    logic        walk_req_en;
    logic        walk_req_rdy = 1'b0;
    logic [35:0] walk_req_va;
    logic [1:0]  walk_req_tag;
    logic        walk_rsp_en = 1'b0;
    logic [1:0]  walk_rsp_tag = '0;
    logic [39:0] walk_rsp_pa = '0;
    logic        walk_rsp_is_big_page = 1'b0;
    logic        walk_rsp_not_present = 1'b0;
    logic        cli_rsp_valid;
    logic [1:0]  cli_rsp_mask;
    logic [35:0] cli_rsp_va;
    logic [39:0] cli_rsp_pa;
    logic        cli_rsp_is_big_page;
    logic        cli_rsp_not_present;
    logic        busy;
    logic [15:0] stat_merge_cnt;
    logic        err_bad_tag;

    cci_mpf_svc_vtp_pt_miss_arb #(
        .N_CLIENTS(NC), .N_TRACK(NT), .VA_IDX_BITS(36), .PA_IDX_BITS(40)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .miss_valid(miss_valid), .miss_rdy(miss_rdy), .miss_va(miss_va),
        .walk_req_en(walk_req_en), .walk_req_rdy(walk_req_rdy),
        .walk_req_va(walk_req_va), .walk_req_tag(walk_req_tag),
        .walk_rsp_en(walk_rsp_en), .walk_rsp_tag(walk_rsp_tag), .walk_rsp_pa(walk_rsp_pa),
        .walk_rsp_is_big_page(walk_rsp_is_big_page), .walk_rsp_not_present(walk_rsp_not_present),
        .cli_rsp_valid(cli_rsp_valid), .cli_rsp_mask(cli_rsp_mask), .cli_rsp_va(cli_rsp_va),
        .cli_rsp_pa(cli_rsp_pa), .cli_rsp_is_big_page(cli_rsp_is_big_page),
        .cli_rsp_not_present(cli_rsp_not_present), .busy(busy),
        .stat_merge_cnt(stat_merge_cnt), .err_bad_tag(err_bad_tag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct { logic [35:0] va; logic [1:0] tag; int cyc; } walk_t;
    typedef struct {
        logic [1:0] mask; logic [35:0] va; logic [39:0] pa; logic big; logic np; int cyc;
    } rsp_t;

    walk_t q_walk[$];
    rsp_t  q_rsp[$];
    int    q_err[$];

    // Reference model: set of pending pages keyed by tracker tag.
    bit          m_valid [NT];
    logic [35:0] m_va    [NT];
    logic [1:0]  m_mask  [NT];
    int          m_alloc_cyc [NT];
    int          m_rr;
    int          m_merges;

    int checks = 0;
    int errors = 0;
    bit in_reset = 1'b1;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endfunction

    function automatic bit model_busy();
        bit b = 1'b0;
        for (int t = 0; t < NT; t++) b |= m_valid[t];
        return b;
    endfunction

    // Drive one cycle of stimulus and advance the reference model.
    task automatic do_cycle(input logic [1:0] mv, input logic [35:0] va0, input logic [35:0] va1,
                            input logic rdy, input logic ren, input logic [1:0] rtag,
                            input logic [39:0] pa, input logic big, input logic np);
        int w, hit, fr;
        logic [35:0] vaw;
        logic [1:0]  exp_rdy;
        bit freeing;
        @(negedge clk);
        miss_valid = mv;  miss_va = {va1, va0};  walk_req_rdy = rdy;
        walk_rsp_en = ren; walk_rsp_tag = rtag; walk_rsp_pa = pa;
        walk_rsp_is_big_page = big; walk_rsp_not_present = np;
        #1;
        w = -1;
        for (int k = 0; k < NC; k++)
            if (w < 0 && mv[(m_rr + k) % NC]) w = (m_rr + k) % NC;
        freeing = ren && m_valid[rtag];
        exp_rdy = '0;
        if (w >= 0) begin
            vaw = (w == 0) ? va0 : va1;
            hit = -1;
            for (int t = 0; t < NT; t++)
                if (hit < 0 && m_valid[t] && !(freeing && t == int'(rtag)) && m_va[t] == vaw) hit = t;
            fr = -1;
            for (int t = NT - 1; t >= 0; t--)
                if (!m_valid[t]) fr = t;
            if (hit >= 0) begin
                m_mask[hit] |= 2'(1 << w);
                if (m_merges < 65535) m_merges++;
                exp_rdy = 2'(1 << w);
            end else if (fr >= 0 && rdy) begin
                m_valid[fr] = 1'b1; m_va[fr] = vaw; m_mask[fr] = 2'(1 << w);
                m_alloc_cyc[fr] = cyc + 1;
                q_walk.push_back('{va: vaw, tag: 2'(fr), cyc: cyc + 1});
                exp_rdy = 2'(1 << w);
            end
            if (exp_rdy != '0) m_rr = (w + 1) % NC;
        end
        chk("miss_rdy", 64'(miss_rdy), 64'(exp_rdy));
        if (freeing) begin
            q_rsp.push_back('{mask: m_mask[rtag], va: m_va[rtag], pa: pa, big: big, np: np, cyc: cyc + 1});
            m_valid[rtag] = 1'b0;
        end else if (ren) begin
            q_err.push_back(cyc + 1);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle('0, '0, '0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    // Answer every outstanding walk so the tracker empties.
    task automatic drain();
        int t;
        for (int n = 0; n < 40; n++) begin
            t = -1;
            for (int k = NT - 1; k >= 0; k--)
                if (m_valid[k] && m_alloc_cyc[k] < cyc) t = k;
            if (t >= 0) do_cycle('0, '0, '0, 1'b1, 1'b1, 2'(t), 40'h5000 + 40'(t), 1'b0, 1'b0);
            else        idle(1);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; in_reset = 1'b1;
        miss_valid = '0; miss_va = '0; walk_req_rdy = 1'b0; walk_rsp_en = 1'b0;
        walk_rsp_tag = '0; walk_rsp_pa = '0; walk_rsp_is_big_page = 1'b0; walk_rsp_not_present = 1'b0;
        for (int t = 0; t < NT; t++) begin m_valid[t] = 1'b0; m_alloc_cyc[t] = 0; end
        m_rr = 0; m_merges = 0;
        q_walk.delete(); q_rsp.delete(); q_err.delete();
        @(negedge clk); #1;
        chk("rst_walk_req_en",   64'(walk_req_en), 64'(0));
        chk("rst_walk_req_va",   64'(walk_req_va), 64'(0));
        chk("rst_walk_req_tag",  64'(walk_req_tag), 64'(0));
        chk("rst_cli_rsp_valid", 64'(cli_rsp_valid), 64'(0));
        chk("rst_cli_rsp_mask",  64'(cli_rsp_mask), 64'(0));
        chk("rst_cli_rsp_pa",    64'(cli_rsp_pa), 64'(0));
        chk("rst_busy",          64'(busy), 64'(0));
        chk("rst_merge_cnt",     64'(stat_merge_cnt), 64'(0));
        chk("rst_err_bad_tag",   64'(err_bad_tag), 64'(0));
        @(negedge clk);
        reset_n = 1'b1; in_reset = 1'b0;
    endtask

    // Monitor: compare registered DUT outputs against the scoreboard queues.
    initial begin
        walk_t w;
        rsp_t  r;
        int    e;
        forever begin
            @(posedge clk); #2;
            if (!in_reset) begin
                if (walk_req_en) begin
                    if (q_walk.size() == 0) chk("walk_req_unexpected", 64'(walk_req_en), 64'(0));
                    else begin
                        w = q_walk.pop_front();
                        chk("walk_req_cycle", 64'(cyc), 64'(w.cyc));
                        chk("walk_req_va", 64'(walk_req_va), 64'(w.va));
                        chk("walk_req_tag", 64'(walk_req_tag), 64'(w.tag));
                    end
                end else if (q_walk.size() != 0 && q_walk[0].cyc <= cyc) begin
                    chk("walk_req_missing", 64'(walk_req_en), 64'(1));
                    w = q_walk.pop_front();
                end

                if (cli_rsp_valid) begin
                    if (q_rsp.size() == 0) chk("cli_rsp_unexpected", 64'(cli_rsp_valid), 64'(0));
                    else begin
                        r = q_rsp.pop_front();
                        chk("cli_rsp_cycle", 64'(cyc), 64'(r.cyc));
                        chk("cli_rsp_mask", 64'(cli_rsp_mask), 64'(r.mask));
                        chk("cli_rsp_va", 64'(cli_rsp_va), 64'(r.va));
                        chk("cli_rsp_pa", 64'(cli_rsp_pa), 64'(r.pa));
                        chk("cli_rsp_big", 64'(cli_rsp_is_big_page), 64'(r.big));
                        chk("cli_rsp_np", 64'(cli_rsp_not_present), 64'(r.np));
                    end
                end else if (q_rsp.size() != 0 && q_rsp[0].cyc <= cyc) begin
                    chk("cli_rsp_missing", 64'(cli_rsp_valid), 64'(1));
                    r = q_rsp.pop_front();
                end

                if (err_bad_tag) begin
                    if (q_err.size() == 0) chk("err_bad_tag_unexpected", 64'(err_bad_tag), 64'(0));
                    else begin
                        e = q_err.pop_front();
                        chk("err_bad_tag_cycle", 64'(cyc), 64'(e));
                    end
                end else if (q_err.size() != 0 && q_err[0] <= cyc) begin
                    chk("err_bad_tag_missing", 64'(err_bad_tag), 64'(1));
                    e = q_err.pop_front();
                end

                chk("stat_merge_cnt", 64'(stat_merge_cnt), 64'(m_merges));
                chk("busy", 64'(busy), 64'(model_busy()));
            end
        end
    end

    task automatic random_phase(input int n);
        logic [1:0] mv, rtag;
        logic [35:0] va0, va1;
        logic rdy, ren;
        int r, ncand;
        int cand [NT];
        for (int i = 0; i < n; i++) begin
            mv  = 2'($urandom_range(0, 3));
            va0 = 36'h100 + 36'($urandom_range(0, 5));
            va1 = 36'h100 + 36'($urandom_range(0, 5));
            rdy = ($urandom_range(0, 3) != 0);
            ren = 1'b0; rtag = '0; ncand = 0;
            r = int'($urandom_range(0, 99));
            if (r < 35) begin
                for (int t = 0; t < NT; t++)
                    if (m_valid[t] && m_alloc_cyc[t] < cyc) begin cand[ncand] = t; ncand++; end
            end else if (r < 38) begin
                for (int t = 0; t < NT; t++)
                    if (!m_valid[t]) begin cand[ncand] = t; ncand++; end
            end
            if (ncand > 0) begin
                ren  = 1'b1;
                rtag = 2'(cand[$urandom_range(0, ncand - 1)]);
            end
            do_cycle(mv, va0, va1, rdy, ren, rtag, {8'($urandom), $urandom},
                     1'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        do_reset();

        // Single miss and its response.
        do_cycle(2'b01, 36'h123, '0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        idle(2);
        do_cycle('0, '0, '0, 1'b1, 1'b1, 2'd0, 40'hABC, 1'b0, 1'b0);
        idle(2);

        // Coalesce two clients onto one walk.
        do_cycle(2'b01, 36'h55, '0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        do_cycle(2'b10, '0, 36'h55, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        idle(1);
        do_cycle('0, '0, '0, 1'b1, 1'b1, 2'd0, 40'h55AA, 1'b1, 1'b0);
        idle(2);

        // Backpressure, then alternating grants.
        for (int i = 0; i < 2; i++) do_cycle(2'b11, 36'h200, 36'h300, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) do_cycle(2'b11, 36'h200, 36'h300, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        drain();

        // Response retiring an entry while the same VA arrives.
        do_cycle(2'b01, 36'h77, '0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        idle(1);
        do_cycle(2'b10, '0, 36'h77, 1'b1, 1'b1, 2'd0, 40'h777, 1'b0, 1'b1);
        idle(2);
        drain();

        // Fill the tracker, stall a new VA, merge a matching one, then free tag 2.
        for (int i = 0; i < 4; i++) do_cycle(2'b01, 36'h400 + 36'(i), '0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) do_cycle(2'b01, 36'h500, '0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        do_cycle(2'b10, '0, 36'h401, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        do_cycle(2'b01, 36'h500, '0, 1'b1, 1'b1, 2'd2, 40'h402, 1'b0, 1'b0);
        do_cycle(2'b01, 36'h500, '0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        idle(2);
        drain();

        random_phase(3000);
        drain();

        // Reset with two walks in flight, then a late response to a stale tag.
        do_cycle(2'b01, 36'h600, '0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        do_cycle(2'b10, '0, 36'h601, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        idle(1);
        do_reset();
        do_cycle('0, '0, '0, 1'b1, 1'b1, 2'd1, 40'h601, 1'b0, 1'b0);
        idle(2);

        random_phase(1000);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cci_mpf_svc_vtp_pt_miss_arb.md
Name: cci_mpf_svc_vtp_pt_miss_arb

Overview:
- Sits directly upstream of the VTP software page-translation service and drives its pt_walk request port.
- Arbitrates TLB-miss requests from N_CLIENTS TLB pipelines.
- Coalesces misses to the same 4KB VA page that are already in flight, so each unique page is walked once.
- Broadcasts each walk response to every client that requested that page.

Parameters:
N_CLIENTS, 2, number of TLB miss sources (2..4)
N_TRACK, 4, in-flight unique walks; must be <= 8 (depth of the downstream request FIFO)
VA_IDX_BITS, 36, 4KB virtual page index width
PA_IDX_BITS, 40, 4KB physical page index width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
miss_valid  in  N_CLIENTS  per-client miss request valid
miss_rdy  out  N_CLIENTS  per-client accept; a transfer occurs when valid&rdy
miss_va  in  N_CLIENTS*VA_IDX_BITS  per-client VA page index; client i uses slice i
walk_req_en  out  1  issue walk to pt_walk server
walk_req_rdy  in  1  pt_walk server reqRdy
walk_req_va  out  VA_IDX_BITS  VA page to walk
walk_req_tag  out  $clog2(N_TRACK)  tracker index
walk_rsp_en  in  1  walk response valid
walk_rsp_tag  in  $clog2(N_TRACK)  tracker index of response
walk_rsp_pa  in  PA_IDX_BITS  translated PA page index
walk_rsp_is_big_page  in  1  2MB mapping
walk_rsp_not_present  in  1  failed translation
cli_rsp_valid  out  1  response broadcast valid
cli_rsp_mask  out  N_CLIENTS  clients receiving this response
cli_rsp_va  out  VA_IDX_BITS  VA page of the response
cli_rsp_pa  out  PA_IDX_BITS  PA page of the response
cli_rsp_is_big_page  out  1  2MB mapping
cli_rsp_not_present  out  1  failed translation
busy  out  1  any tracker entry valid (registered)
stat_merge_cnt  out  16  saturating count of coalesced misses
err_bad_tag  out  1  one-cycle pulse on a response to an invalid entry

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - All tracker entries invalid.
  - RR pointer = 0.
  - walk_req_en = 0; cli_rsp_valid = 0; cli_rsp_mask = 0.
  - busy = 0; stat_merge_cnt = 0; err_bad_tag = 0.
  - Data outputs are 0.
  - No response is emitted for walks in flight at reset. Late walk_rsp_en for those walks raises err_bad_tag.
- Tracker entry state: valid, va, client_mask[N_CLIENTS]. Each entry is FREE or PENDING.
- Arbitration:
  - Round-robin over clients with miss_valid, starting at the RR pointer.
  - At most one grant per cycle.
  - The RR pointer advances to winner+1 (mod N_CLIENTS) only on an accepted transfer.
- Match: the winner's VA is compared with all PENDING entries, excluding any entry being freed this cycle.
- Merge on hit:
  - miss_rdy[winner] = 1.
  - client_mask of the matching entry |= winner bit.
  - No walk is issued; stat_merge_cnt increments, saturating at 0xFFFF.
  - Independent of walk_req_rdy.
- Allocate on miss:
  - Requires a FREE entry (as of cycle start) and walk_req_rdy = 1.
  - Allocates the lowest free index: sets va and mask = winner bit.
  - miss_rdy[winner] = 1.
  - Registers walk_req_en = 1, walk_req_va, walk_req_tag; asserted for exactly one cycle.
  - If either condition fails: miss_rdy = 0 for all clients, RR pointer unchanged.
- miss_rdy is combinational from miss_valid/miss_va/state/walk_req_rdy, and only the granted bit can be 1.
- Response path, 1-cycle latency:
  - walk_rsp_en to a PENDING tag: next cycle cli_rsp_valid = 1 with that entry's mask and va, plus walk_rsp_pa, walk_rsp_is_big_page, walk_rsp_not_present. The entry goes FREE at the end of the response cycle.
  - walk_rsp_en to a FREE tag: no cli_rsp_valid; err_bad_tag pulses the next cycle.
- Simultaneous events in one cycle:
  - A merge against the entry being freed is forbidden; the request is treated as a miss and may allocate a different free entry.
  - The freed index is not allocatable until the next cycle.
- Full: with all N_TRACK entries PENDING, new-VA misses stall; matching VAs still merge.
- Responses may return in any tag order.
- busy is registered as OR of all entry valid bits.

Test Plan:
- Single miss: client0 VA 0x123 -> walk_req_en with tag 0, VA 0x123. walk_rsp tag 0, PA 0xABC -> one cycle later cli_rsp_valid, mask 0b01, PA 0xABC.
- Coalesce: client0 and client1 both send VA 0x55 in consecutive cycles -> one walk only, stat_merge_cnt = 1. Response -> mask 0b11.
- Full stall: 4 distinct VAs outstanding -> 5th distinct VA held with miss_rdy = 0. A 5th request matching an outstanding VA is accepted. Response to tag 2 -> stalled request allocates tag 2 on the following cycle.
- Same-cycle free+match: response tag 0 (VA 0x77) while client1 sends VA 0x77 -> new walk issued on tag 1. Response mask excludes client1.
- Backpressure/fairness: walk_req_rdy = 0 with both clients presenting new VAs -> no accept. After release, grants alternate client0, client1, client0.
- Reset mid-walk: reset_n low with 2 entries pending -> all outputs cleared. Subsequent walk_rsp_en tag 1 -> err_bad_tag pulse, no cli_rsp_valid.
